// File: rtl/acfa_log_ctrl.sv
// ACFA control-flow log writer: queues (src, dest) branch events, writes each as two 16-bit
// log words, requests verifier flushes, and locks into a sticky violation on tamper/overflow.
module acfa_log_ctrl #(
   parameter logic [15:0] LOG_BASE   = 16'h0140,
   parameter int          LOG_DEPTH  = 64,
   parameter int          PEND_DEPTH = 2
) (
   input  logic        clk,
   input  logic        puc,
   input  logic        ev_valid,
   input  logic [15:0] ev_src,
   input  logic [15:0] ev_dest,
   input  logic        er_exit,
   input  logic        data_wr,
   input  logic [15:0] data_addr,
   input  logic        dma_en,
   input  logic [15:0] dma_addr,
   input  logic        flush_ack,
   output logic        log_wen,
   output logic [15:0] log_addr,
   output logic [15:0] log_wdata,
   output logic [15:0] log_ptr,
   output logic        flush,
   output logic        ER_done,
   output logic        reset
);
   localparam logic [15:0]    LOG_END  = 16'(32'(LOG_BASE) + 4 * LOG_DEPTH - 1);
   localparam logic [15:0]    DEPTH16  = 16'(LOG_DEPTH);
   localparam int             PW       = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
   localparam int             CW       = $clog2(PEND_DEPTH + 1);
   localparam logic [PW-1:0]  PTR_LAST = PW'(PEND_DEPTH - 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(PEND_DEPTH);

   typedef enum logic [2:0] {IDLE, WR_SRC, WR_DST, FLUSH, DONE, VIOL} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fifo_q [PEND_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   entry_q, entry_d;
   logic [15:0]   log_ptr_q, log_ptr_d;
   logic          er_pending_q, er_pending_d;
   logic          log_wen_q, log_wen_d, flush_q, flush_d;
   logic          er_done_q, er_done_d, reset_q, reset_d;
   logic [15:0]   log_addr_q, log_addr_d, log_wdata_q, log_wdata_d;
   logic [15:0]   entry_addr;

   logic fifo_empty, fifo_full, ev_accept, last_entry, do_pop, do_push, overflow, tamper;

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CNT_FULL);
   assign ev_accept  = ev_valid && (state_q != DONE) && (state_q != VIOL);
   assign last_entry = ((log_ptr_q + 16'd1) == DEPTH16);
   // A pop is exactly a transition into WR_SRC.
   assign do_pop     = !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == WR_DST) && !last_entry));
   assign overflow   = ev_accept && fifo_full && !do_pop;
   assign do_push    = ev_accept && (!fifo_full || do_pop);
   assign tamper     = (data_wr && (data_addr >= LOG_BASE) && (data_addr <= LOG_END)) ||
                       (dma_en  && (dma_addr  >= LOG_BASE) && (dma_addr  <= LOG_END));

   assign entry_d  = do_pop ? fifo_q[rd_ptr_q] : entry_q;
   assign cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
   assign wr_ptr_d = !do_push ? wr_ptr_q : ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1));
   assign rd_ptr_d = !do_pop  ? rd_ptr_q : ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1));

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d      = state_q;
      log_ptr_d    = log_ptr_q;
      er_pending_d = er_pending_q;
      if (er_exit && (state_q != DONE) && (state_q != VIOL)) er_pending_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (!fifo_empty)       state_d = WR_SRC;
            else if (er_pending_q) state_d = FLUSH;
         end
         WR_SRC: state_d = WR_DST;
         WR_DST: begin
            log_ptr_d = log_ptr_q + 16'd1;
            if (last_entry)       state_d = FLUSH;
            else if (!fifo_empty) state_d = WR_SRC;
            else                  state_d = IDLE;
         end
         FLUSH: begin
            if (flush_ack) begin
               log_ptr_d = '0;
               // The final flush only completes if no event is queued or arriving.
               state_d   = (er_pending_q && fifo_empty && !do_push) ? DONE : IDLE;
            end
         end
         default: ;
      endcase
      if (tamper || overflow) begin
         state_d   = VIOL;
         log_ptr_d = log_ptr_q;
      end
   end

   always_comb begin
      entry_addr  = LOG_BASE + {log_ptr_d[13:0], 2'b00};
      log_wen_d   = 1'b0;
      log_addr_d  = '0;
      log_wdata_d = '0;
      case (state_d)
         WR_SRC: begin
            log_wen_d   = 1'b1;
            log_addr_d  = entry_addr;
            log_wdata_d = entry_d[31:16];
         end
         WR_DST: begin
            log_wen_d   = 1'b1;
            log_addr_d  = entry_addr + 16'd2;
            log_wdata_d = entry_d[15:0];
         end
         default: ;
      endcase
      flush_d   = (state_d == FLUSH);
      er_done_d = (state_d == DONE);
      reset_d   = (state_d == VIOL);
   end

   always_ff @(posedge clk) begin
      if (puc) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         entry_q      <= '0;
         log_ptr_q    <= '0;
         er_pending_q <= 1'b0;
         log_wen_q    <= 1'b0;
         log_addr_q   <= '0;
         log_wdata_q  <= '0;
         flush_q      <= 1'b0;
         er_done_q    <= 1'b0;
         reset_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         entry_q      <= entry_d;
         log_ptr_q    <= log_ptr_d;
         er_pending_q <= er_pending_d;
         log_wen_q    <= log_wen_d;
         log_addr_q   <= log_addr_d;
         log_wdata_q  <= log_wdata_d;
         flush_q      <= flush_d;
         er_done_q    <= er_done_d;
         reset_q      <= reset_d;
      end
   end

   // NOTE: payload slots are not reset; cnt_q alone says which ones hold valid events.
   always_ff @(posedge clk) begin
      if (do_push) fifo_q[wr_ptr_q] <= {ev_src, ev_dest};
   end

   assign log_wen   = log_wen_q;
   assign log_addr  = log_addr_q;
   assign log_wdata = log_wdata_q;
   assign log_ptr   = log_ptr_q;
   assign flush     = flush_q;
   assign ER_done   = er_done_q;
   assign reset     = reset_q;

endmodule

// File: tb/tb_acfa_log_ctrl.sv
// Bench for acfa_log_ctrl: two instances (LOG_DEPTH 64 and 4) share stimulus and are compared
// every cycle against a queue-based behavioural model, plus directed boundary scenarios.
module tb_acfa_log_ctrl;
   localparam int PEND = 2;
   localparam int M_IDLE = 0, M_SRC = 1, M_DST = 2, M_FLUSH = 3, M_DONE = 4, M_VIOL = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        puc, ev_valid, er_exit, data_wr, dma_en, flush_ack;
   logic [15:0] ev_src, ev_dest, data_addr, dma_addr;

   logic        wen0, flush0, done0, rst0, wen1, flush1, done1, rst1;
   logic [15:0] addr0, wdata0, ptr0, addr1, wdata1, ptr1;
   logic [63:0] vec0, vec1;

   assign vec0 = {12'h0, wen0, flush0, done0, rst0, addr0, wdata0, ptr0};
   assign vec1 = {12'h0, wen1, flush1, done1, rst1, addr1, wdata1, ptr1};

   acfa_log_ctrl #(.LOG_BASE(16'h0140), .LOG_DEPTH(64), .PEND_DEPTH(PEND)) dut_d64 (
      .clk(clk), .puc(puc), .ev_valid(ev_valid), .ev_src(ev_src), .ev_dest(ev_dest),
      .er_exit(er_exit), .data_wr(data_wr), .data_addr(data_addr), .dma_en(dma_en),
      .dma_addr(dma_addr), .flush_ack(flush_ack), .log_wen(wen0), .log_addr(addr0),
      .log_wdata(wdata0), .log_ptr(ptr0), .flush(flush0), .ER_done(done0), .reset(rst0)
   );

   acfa_log_ctrl #(.LOG_BASE(16'h0140), .LOG_DEPTH(4), .PEND_DEPTH(PEND)) dut_d4 (
      .clk(clk), .puc(puc), .ev_valid(ev_valid), .ev_src(ev_src), .ev_dest(ev_dest),
      .er_exit(er_exit), .data_wr(data_wr), .data_addr(data_addr), .dma_en(dma_en),
      .dma_addr(dma_addr), .flush_ack(flush_ack), .log_wen(wen1), .log_addr(addr1),
      .log_wdata(wdata1), .log_ptr(ptr1), .flush(flush1), .ER_done(done1), .reset(rst1)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural model: pending events as a shift queue, one activity per instance.
   int          m_depth [2];
   int          m_mode  [2];
   int          m_cnt   [2];
   int          m_ptr   [2];
   bit          m_er    [2];
   logic [31:0] m_cur   [2];
   logic [31:0] m_pend  [2][PEND];

   task automatic model_step(input int k);
      int d;
      int last_addr;
      int mode_n;
      bit tamp, acc, pop, ovf;
      d = m_depth[k];
      if (puc) begin
         m_mode[k] = M_IDLE; m_cnt[k] = 0; m_ptr[k] = 0; m_er[k] = 1'b0; m_cur[k] = '0;
         return;
      end
      last_addr = 'h140 + 4 * d - 1;
      tamp = (data_wr && int'(data_addr) >= 'h140 && int'(data_addr) <= last_addr) ||
             (dma_en  && int'(dma_addr)  >= 'h140 && int'(dma_addr)  <= last_addr);
      acc  = ev_valid && m_mode[k] != M_DONE && m_mode[k] != M_VIOL;
      pop  = m_cnt[k] > 0 &&
             (m_mode[k] == M_IDLE || (m_mode[k] == M_DST && m_ptr[k] + 1 != d));
      ovf  = acc && m_cnt[k] == PEND && !pop;
      if (tamp || ovf) begin
         m_mode[k] = M_VIOL;
         return;
      end
      mode_n = m_mode[k];
      case (m_mode[k])
         M_IDLE:  if (m_cnt[k] > 0) mode_n = M_SRC; else if (m_er[k]) mode_n = M_FLUSH;
         M_SRC:   mode_n = M_DST;
         M_DST: begin
            m_ptr[k]++;
            if (m_ptr[k] == d)     mode_n = M_FLUSH;
            else if (m_cnt[k] > 0) mode_n = M_SRC;
            else                   mode_n = M_IDLE;
         end
         M_FLUSH: if (flush_ack) begin
            m_ptr[k] = 0;
            mode_n = (m_er[k] && m_cnt[k] == 0 && !acc) ? M_DONE : M_IDLE;
         end
         default: ;
      endcase
      if (er_exit && m_mode[k] != M_DONE && m_mode[k] != M_VIOL) m_er[k] = 1'b1;
      if (pop) begin
         m_cur[k] = m_pend[k][0];
         for (int j = 0; j < PEND - 1; j++) m_pend[k][j] = m_pend[k][j+1];
         m_cnt[k]--;
      end
      if (acc) begin
         m_pend[k][m_cnt[k]] = {ev_src, ev_dest};
         m_cnt[k]++;
      end
      m_mode[k] = mode_n;
   endtask

   function automatic logic [63:0] exp_vec(input int k);
      logic        wen, fl, dn, rs;
      logic [15:0] a, w;
      wen = 1'b0; fl = 1'b0; dn = 1'b0; rs = 1'b0; a = '0; w = '0;
      case (m_mode[k])
         M_SRC:   begin wen = 1'b1; a = 16'('h140 + 4 * m_ptr[k]);     w = m_cur[k][31:16]; end
         M_DST:   begin wen = 1'b1; a = 16'('h140 + 4 * m_ptr[k] + 2); w = m_cur[k][15:0];  end
         M_FLUSH: fl = 1'b1;
         M_DONE:  dn = 1'b1;
         M_VIOL:  rs = 1'b1;
         default: ;
      endcase
      return {12'h0, wen, fl, dn, rs, a, w, 16'(m_ptr[k])};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check("d64 outputs", vec0, exp_vec(0));
      check("d4 outputs",  vec1, exp_vec(1));
   endtask

   task automatic idle_inputs();
      puc = 1'b0; ev_valid = 1'b0; er_exit = 1'b0; data_wr = 1'b0; dma_en = 1'b0;
      flush_ack = 1'b0; ev_src = '0; ev_dest = '0; data_addr = '0; dma_addr = '0;
   endtask

   task automatic do_puc();
      puc = 1'b1;
      cycle();
      puc = 1'b0;
   endtask

   task automatic send_event(input logic [15:0] s, input logic [15:0] d);
      ev_valid = 1'b1; ev_src = s; ev_dest = d;
      cycle();
      ev_valid = 1'b0;
   endtask

   initial begin
      m_depth[0] = 64;
      m_depth[1] = 4;
      idle_inputs();
      puc = 1'b1;
      cycle();
      cycle();
      puc = 1'b0;
      check("reset d64", vec0, 64'h0);
      check("reset d4",  vec1, 64'h0);

      // Single event: src at t+2, dest at t+3, then log_ptr=1.
      send_event(16'hE100, 16'hE200);
      cycle();
      check("single src",  {wen0, addr0, wdata0}, {1'b1, 16'h0140, 16'hE100});
      cycle();
      check("single dest", {wen0, addr0, wdata0}, {1'b1, 16'h0142, 16'hE200});
      cycle();
      check("single done", {wen0, ptr0}, {1'b0, 16'd1});

      // Fill the depth-4 window, stall the flush, then write entry 0 of the next window.
      for (int i = 0; i < 3; i++) begin
         send_event(16'hA000 + 16'(i), 16'hB000 + 16'(i));
         repeat (3) cycle();
      end
      for (int i = 0; i < 5; i++) begin
         check("d4 flush held", flush1, 1'b1);
         cycle();
      end
      flush_ack = 1'b1;
      cycle();
      flush_ack = 1'b0;
      check("d4 ptr cleared", {flush1, ptr1}, {1'b0, 16'd0});
      send_event(16'hE500, 16'hE600);
      cycle();
      check("d4 wrap write", {wen1, addr1, wdata1}, {1'b1, 16'h0140, 16'hE500});
      check("d64 entry4",    {wen0, addr0, wdata0}, {1'b1, 16'h0150, 16'hE500});
      repeat (3) cycle();

      // Tamper window edges.
      data_wr = 1'b1; data_addr = 16'h0240; cycle(); data_wr = 1'b0; cycle();
      check("d64 0240 outside", rst0, 1'b0);
      data_wr = 1'b1; data_addr = 16'h013F; cycle(); data_wr = 1'b0; cycle();
      check("013F outside", {rst0, rst1}, 2'b00);
      dma_en = 1'b1; dma_addr = 16'h023F; cycle(); dma_en = 1'b0;
      check("d64 dma 023F tamper", rst0, 1'b1);
      check("d4 dma 023F outside", rst1, 1'b0);
      do_puc();
      data_wr = 1'b1; data_addr = 16'h0150; cycle(); data_wr = 1'b0;
      check("d64 0150 tamper", rst0, 1'b1);
      check("d4 0150 outside", rst1, 1'b0);
      data_wr = 1'b1; data_addr = 16'h014F; cycle(); data_wr = 1'b0;
      check("d4 014F tamper", rst1, 1'b1);
      do_puc();

      // Overflow: five back-to-back events into a 2-deep FIFO.
      for (int i = 0; i < 5; i++) begin
         ev_valid = 1'b1; ev_src = 16'($urandom); ev_dest = 16'($urandom);
         cycle();
         if (i == 3) check("no ovf yet", rst0, 1'b0);
      end
      ev_valid = 1'b0;
      check("ovf reset", {rst0, rst1}, 2'b11);
      repeat (3) cycle();
      check("ovf sticky", {rst0, rst1, wen0, flush0}, 4'b1100);
      do_puc();
      check("puc clears viol", {rst0, rst1}, 2'b00);

      // Final report with one queued event.
      send_event(16'hC100, 16'hC200);
      er_exit = 1'b1; cycle(); er_exit = 1'b0;
      repeat (3) cycle();
      check("final flush", {flush0, flush1}, 2'b11);
      flush_ack = 1'b1; cycle(); flush_ack = 1'b0;
      check("ER_done", {done0, done1, ptr0}, {2'b11, 16'd0});
      send_event(16'h1111, 16'h2222);
      for (int i = 0; i < 3; i++) begin
         check("done no write", {wen0, wen1, done0}, 3'b001);
         cycle();
      end
      do_puc();

      // puc while flushing with log_ptr=3.
      for (int i = 0; i < 3; i++) begin
         send_event(16'h3000 + 16'(i), 16'h4000 + 16'(i));
         repeat (3) cycle();
      end
      er_exit = 1'b1; cycle(); er_exit = 1'b0;
      cycle();
      check("flush ptr3", {flush0, ptr0}, {1'b1, 16'd3});
      do_puc();
      check("puc in flush d64", vec0, 64'h0);
      check("puc in flush d4",  vec1, 64'h0);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bool_stuck: begin
            bit stuck;
            stuck = (m_mode[0] inside {M_DONE, M_VIOL}) && (m_mode[1] inside {M_DONE, M_VIOL});
            puc   = stuck ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
         end
         ev_valid  = ($urandom_range(0, 99) < 30);
         ev_src    = 16'($urandom);
         ev_dest   = 16'($urandom);
         er_exit   = ($urandom_range(0, 149) == 0);
         flush_ack = ($urandom_range(0, 3) == 0);
         data_wr   = ($urandom_range(0, 3) == 0);
         dma_en    = ($urandom_range(0, 3) == 0);
         data_addr = ($urandom_range(0, 39) == 0) ? 16'($urandom_range('h130, 'h250)) :
                     ($urandom_range(0, 1) == 0)  ? 16'($urandom_range(0, 'h13F)) :
                                                    16'($urandom_range('h250, 'hFFFF));
         dma_addr  = ($urandom_range(0, 59) == 0) ? 16'($urandom_range('h130, 'h250)) :
                                                    16'($urandom_range('h250, 'hFFFF));
         cycle();
      end
      idle_inputs();
      cycle();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
